dist_ram_fifo: RTL

DIST_RAM_FIFO -- requirements
Module: dist_ram_fifo

---
 rtl/dcp_pkg.sv | 13 +
 rtl/dist_ram_dp.sv | 29 ++
 rtl/dist_ram_fifo.sv | 93 +++++++++
 3 files changed

// File: rtl/dcp_pkg.sv
// Shared constants for the distributed-RAM FIFO slice: default geometry and a
// depth helper. Holds nothing specific to one block.
package dcp_pkg;

  localparam int DEFAULT_WIDTH = 14;
  localparam int DEFAULT_ABITS = 6;

  // Number of words addressed by an abits-wide pointer.
  function automatic int depth_of(input int abits);
    return 1 << abits;
  endfunction

endpackage

// File: rtl/dist_ram_dp.sv
// Simple dual-port distributed RAM: one synchronous write port and one
// asynchronous read port. Storage only; no pointer or flag logic lives here.
module dist_ram_dp
  import dcp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ABITS = DEFAULT_ABITS
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(ABITS);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store wdata at waddr on the rising edge when enabled.
  // NOTE: the array has no reset so it maps onto LUT RAM; a reset would force flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dist_ram_fifo.sv
// First-word-fall-through FIFO over distributed RAM. Pointers, occupancy and
// all status flags are kept here; flags are registered from the next-state
// count so they line up with COUNT in the same cycle.
module dist_ram_fifo
  import dcp_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int ABITS    = DEFAULT_ABITS,
  parameter int AF_LEVEL = depth_of(ABITS) - 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             WR,
  input  logic [WIDTH-1:0] D,
  input  logic             RD,
  output logic [WIDTH-1:0] Q,
  output logic             EMPTY,
  output logic             FULL,
  output logic             AFULL,
  output logic [ABITS:0]   COUNT,
  output logic             OVF,
  output logic             UNF
);

  localparam int             DEPTH   = depth_of(ABITS);
  localparam logic [ABITS:0] DEPTH_C = (ABITS + 1)'(DEPTH);
  localparam logic [ABITS:0] AF_C    = (ABITS + 1)'(AF_LEVEL);

  logic [ABITS-1:0] wptr;
  logic [ABITS-1:0] rptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [ABITS:0]   count_next;

  // Acceptance uses the registered flags, i.e. the pre-edge state.
  assign wr_ok = WR & ~FULL;
  assign rd_ok = RD & ~EMPTY;

  // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    count_next = COUNT;
    if (wr_ok && !rd_ok)      count_next = COUNT + (ABITS + 1)'(1);
    else if (rd_ok && !wr_ok) count_next = COUNT - (ABITS + 1)'(1);
  end

  // Pointer, occupancy and flag registers; CLR flushes and overrides WR/RD.
  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      FULL  <= 1'b0;
      AFULL <= 1'b0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
    end else if (CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      FULL  <= 1'b0;
      AFULL <= 1'b0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ABITS'(1);
      if (rd_ok) rptr <= rptr + ABITS'(1);
      COUNT <= count_next;
      EMPTY <= (count_next == '0);
      FULL  <= (count_next == DEPTH_C);
      AFULL <= (count_next >= AF_C);
      if (WR && FULL)  OVF <= 1'b1;
      if (RD && EMPTY) UNF <= 1'b1;
    end
  end

  dist_ram_dp #(
    .WIDTH (WIDTH),
    .ABITS (ABITS)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_ok && !CLR),
    .waddr (wptr),
    .wdata (D),
    .raddr (rptr),
    .rdata (Q)
  );

endmodule
